// File: rtl/frame_downsampler_pkg.sv
// Shared dimensions, state encoding and width helper for the camera-side
// frame downsampler and the disparity stage that consumes its 47x30 image.
package frame_downsampler_pkg;

   localparam int IN_WIDTH    = 752;
   localparam int IN_HEIGHT   = 480;
   localparam int SCALE_LOG2  = 4;
   localparam int SCALE       = 1 << SCALE_LOG2;
   localparam int OUT_WIDTH   = IN_WIDTH >> SCALE_LOG2;
   localparam int OUT_HEIGHT  = IN_HEIGHT >> SCALE_LOG2;
   localparam int RRST_CYCLES = 2;
   localparam int ACC_W       = 8 + 2 * SCALE_LOG2;

   // Counter width that never collapses to zero bits for tiny ranges.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int X_W   = width_of(IN_WIDTH);
   localparam int Y_W   = width_of(IN_HEIGHT);
   localparam int IDX_W = width_of(OUT_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RRST  = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_EMIT  = 3'd4
   } ds_state_t;

endpackage

// File: rtl/frame_downsampler_block_accum.sv
// Bank of per-output-column block accumulators: one add port fed by the
// read pipeline and one read-and-clear port used while emitting a row.
module frame_downsampler_block_accum #(
   parameter int N_ENTRIES = frame_downsampler_pkg::OUT_WIDTH,
   parameter int ACC_W     = frame_downsampler_pkg::ACC_W,
   parameter int IDX_W     = frame_downsampler_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             add_valid,
   input  logic [IDX_W-1:0] add_idx,
   input  logic [7:0]       add_data,
   input  logic             rd_clr,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [ACC_W-1:0] rd_data
);
   import frame_downsampler_pkg::*;

   logic [ACC_W-1:0] acc_view [N_ENTRIES];

   genvar gi;
   generate
      for (gi = 0; gi < N_ENTRIES; gi++) begin : g_acc
         logic [ACC_W-1:0] acc_reg;

         // Clear wins over add; the FSM never requests both in one cycle.
         always_ff @(posedge clk) begin
            if (reset) begin
               acc_reg <= '0;
            end else if (rd_clr && (rd_idx == IDX_W'(gi))) begin
               acc_reg <= '0;
            end else if (add_valid && (add_idx == IDX_W'(gi))) begin
               acc_reg <= acc_reg + ACC_W'(add_data);
            end
         end

         assign acc_view[gi] = acc_reg;
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < N_ENTRIES) begin
         rd_data = acc_view[rd_idx];
      end
   end

endmodule

// File: rtl/frame_downsampler.sv
// Reads one camera frame from the selected FIFO in raster order and emits the
// SCALE x SCALE block averages as a row-by-row pixel stream.
module frame_downsampler #(
   parameter int IN_WIDTH    = frame_downsampler_pkg::IN_WIDTH,
   parameter int IN_HEIGHT   = frame_downsampler_pkg::IN_HEIGHT,
   parameter int SCALE_LOG2  = frame_downsampler_pkg::SCALE_LOG2,
   parameter int RRST_CYCLES = frame_downsampler_pkg::RRST_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       new_image,
   input  logic       image_sel,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_sel,
   output logic       fifo_rrst,
   output logic       fifo_rd,
   output logic [7:0] image_data,
   output logic       buffer_ready,
   output logic       buffer_href,
   output logic       buffer_vref,
   output logic       busy
);
   import frame_downsampler_pkg::*;

   localparam int SCALE      = 1 << SCALE_LOG2;
   localparam int OUT_WIDTH  = IN_WIDTH >> SCALE_LOG2;
   localparam int OUT_HEIGHT = IN_HEIGHT >> SCALE_LOG2;
   localparam int ACC_W      = 8 + 2 * SCALE_LOG2;
   localparam int X_W        = width_of(IN_WIDTH);
   localparam int Y_W        = width_of(IN_HEIGHT + 1);
   localparam int IDX_W      = width_of(OUT_WIDTH);
   localparam int ROW_W      = width_of(OUT_HEIGHT);
   localparam int RC_W       = width_of(RRST_CYCLES);

   ds_state_t        state_reg, state_next;
   logic [X_W-1:0]   x_reg, x_next;
   logic [Y_W-1:0]   y_reg, y_next;
   logic [ROW_W-1:0] row_reg, row_next;
   logic [IDX_W-1:0] emit_idx_reg, emit_idx_next;
   logic [RC_W-1:0]  rrst_cnt_reg, rrst_cnt_next;
   logic             sel_reg, sel_next;
   logic             vref_reg, vref_next;

   logic             sample_valid_reg;
   logic             sample_keep_reg;
   logic [IDX_W-1:0] sample_idx_reg;

   logic             rd_en;
   logic             emitting;
   logic             block_last_line;
   logic [X_W-1:0]   col_full;
   logic [ACC_W-1:0] rd_acc;

   assign rd_en           = (state_reg == ST_READ) && !fifo_empty;
   assign emitting        = (state_reg == ST_EMIT);
   assign col_full        = x_reg >> SCALE_LOG2;
   assign block_last_line = (y_reg & Y_W'(SCALE - 1)) == Y_W'(SCALE - 1);

   always_comb begin
      state_next    = state_reg;
      x_next        = x_reg;
      y_next        = y_reg;
      row_next      = row_reg;
      emit_idx_next = emit_idx_reg;
      rrst_cnt_next = rrst_cnt_reg;
      sel_next      = sel_reg;
      vref_next     = vref_reg;
      case (state_reg)
         ST_IDLE: begin
            if (new_image) begin
               sel_next      = image_sel;
               x_next        = '0;
               y_next        = '0;
               row_next      = '0;
               emit_idx_next = '0;
               rrst_cnt_next = '0;
               state_next    = ST_RRST;
            end
         end
         ST_RRST: begin
            if (rrst_cnt_reg == RC_W'(RRST_CYCLES - 1)) begin
               state_next = ST_READ;
            end else begin
               rrst_cnt_next = rrst_cnt_reg + RC_W'(1);
            end
         end
         ST_READ: begin
            if (rd_en) begin
               if (x_reg == X_W'(IN_WIDTH - 1)) begin
                  x_next = '0;
                  y_next = y_reg + Y_W'(1);
                  // Last read of a block row; its sample lands during DRAIN.
                  if (block_last_line) begin
                     state_next = ST_DRAIN;
                  end
               end else begin
                  x_next = x_reg + X_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            emit_idx_next = '0;
            state_next    = ST_EMIT;
         end
         ST_EMIT: begin
            if ((emit_idx_reg == '0) && (row_reg == '0)) begin
               vref_next = 1'b1;
            end
            if (emit_idx_reg == IDX_W'(OUT_WIDTH - 1)) begin
               emit_idx_next = '0;
               if (row_reg == ROW_W'(OUT_HEIGHT - 1)) begin
                  vref_next  = 1'b0;
                  state_next = ST_IDLE;
               end else begin
                  row_next   = row_reg + ROW_W'(1);
                  state_next = ST_READ;
               end
            end else begin
               emit_idx_next = emit_idx_reg + IDX_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         x_reg            <= '0;
         y_reg            <= '0;
         row_reg          <= '0;
         emit_idx_reg     <= '0;
         rrst_cnt_reg     <= '0;
         sel_reg          <= 1'b0;
         vref_reg         <= 1'b0;
         sample_valid_reg <= 1'b0;
         sample_keep_reg  <= 1'b0;
         sample_idx_reg   <= '0;
      end else begin
         state_reg        <= state_next;
         x_reg            <= x_next;
         y_reg            <= y_next;
         row_reg          <= row_next;
         emit_idx_reg     <= emit_idx_next;
         rrst_cnt_reg     <= rrst_cnt_next;
         sel_reg          <= sel_next;
         vref_reg         <= vref_next;
         // FIFO data follows the read by one cycle, so tag it now.
         sample_valid_reg <= rd_en;
         sample_keep_reg  <= col_full < X_W'(OUT_WIDTH);
         sample_idx_reg   <= IDX_W'(col_full);
      end
   end

   frame_downsampler_block_accum #(
      .N_ENTRIES (OUT_WIDTH),
      .ACC_W     (ACC_W),
      .IDX_W     (IDX_W)
   ) u_accum (
      .clk       (clk),
      .reset     (reset),
      .add_valid (sample_valid_reg && sample_keep_reg),
      .add_idx   (sample_idx_reg),
      .add_data  (fifo_data),
      .rd_clr    (emitting),
      .rd_idx    (emit_idx_reg),
      .rd_data   (rd_acc)
   );

   assign fifo_sel     = sel_reg;
   assign fifo_rrst    = (state_reg == ST_RRST);
   assign fifo_rd      = rd_en;
   assign image_data   = emitting ? 8'(rd_acc >> (ACC_W - 8)) : 8'd0;
   assign buffer_ready = emitting;
   assign buffer_href  = emitting;
   assign buffer_vref  = emitting || vref_reg;
   assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_frame_downsampler.sv
// Scoreboard bench on a reduced 76x24 frame with 8x8 blocks (9x3 outputs,
// four trailing columns per line discarded) fed by a behavioural FIFO.
module tb_frame_downsampler;

   localparam int IW   = 76;
   localparam int IH   = 24;
   localparam int SL   = 3;
   localparam int SC   = 1 << SL;
   localparam int OW   = IW >> SL;
   localparam int OH   = IH >> SL;
   localparam int NPIX = OW * OH;

   logic       clk = 1'b0;
   logic       reset;
   logic       new_image;
   logic       image_sel;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_sel;
   logic       fifo_rrst;
   logic       fifo_rd;
   logic [7:0] image_data;
   logic       buffer_ready;
   logic       buffer_href;
   logic       buffer_vref;
   logic       busy;

   int         errors = 0;
   int         checks = 0;
   int         mode = 0;
   bit         stall_en = 1'b0;
   int         ptr = 0;
   int         ncyc = 0;
   int         rd_ncyc = -100;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   frame_downsampler #(
      .IN_WIDTH    (IW),
      .IN_HEIGHT   (IH),
      .SCALE_LOG2  (SL),
      .RRST_CYCLES (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .new_image    (new_image),
      .image_sel    (image_sel),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .fifo_sel     (fifo_sel),
      .fifo_rrst    (fifo_rrst),
      .fifo_rd      (fifo_rd),
      .image_data   (image_data),
      .buffer_ready (buffer_ready),
      .buffer_href  (buffer_href),
      .buffer_vref  (buffer_vref),
      .busy         (busy)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Input pixel at (x, y); discarded columns carry noise that must never land.
   function automatic logic [7:0] pix(input int m, input int x, input int y);
      int v;
      if (x >= OW * SC) return 8'($urandom);
      case (m)
         0: return 8'h80;
         1: return 8'(((y / SC) * OW + x / SC) * 37 + 5);
         2: begin
            v = (y % SC) * SC + (x % SC);
            return 8'(v * 4 + (v & 1));
         end
         default: return 8'hFF;
      endcase
   endfunction

   // Hand-derived block averages: mode 2 sums to 8096 over 64 pixels -> 126.
   function automatic logic [7:0] exp_pix(input int m, input int k);
      case (m)
         0: return 8'h80;
         1: return 8'(k * 37 + 5);
         2: return 8'd126;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input bit sel, input int m);
      mode = m;
      for (int k = 0; k < NPIX; k++) exp_q.push_back(exp_pix(m, k));
      $display("frame request sel=%0d mode=%0d stall=%0d", sel, m, stall_en);
      image_sel = sel;
      new_image = 1'b1;
      tick();
      new_image = 1'b0;
      image_sel = 1'b0;
      check("fifo_sel", fifo_sel, sel);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 10000) begin
         tick();
         n++;
      end
      check("frame_done_in_budget", busy, 0);
   endtask

   task automatic wait_ptr(input int target);
      int n;
      n = 0;
      while (ptr < target && n < 10000) begin
         tick();
         n++;
      end
      check("ptr_reached", int'(ptr >= target), 1);
   endtask

   // Behavioural FIFO: data appears one cycle after an accepted read.
   initial begin
      bit rd_s;
      bit rrst_s;
      fifo_data = 8'h00;
      forever begin
         @(negedge clk);
         rd_s   = fifo_rd;
         rrst_s = fifo_rrst;
         @(posedge clk);
         #1;
         if (rrst_s) ptr = 0;
         if (rd_s) begin
            fifo_data = pix(mode, ptr % IW, ptr / IW);
            ptr++;
         end else begin
            fifo_data = 8'($urandom);
         end
      end
   end

   initial begin
      fifo_empty = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         fifo_empty = stall_en && ($urandom_range(0, 99) < 30);
      end
   end

   // Monitor: pops the scoreboard on every output pixel and checks framing.
   initial begin
      int         href_run;
      int         frame_pix;
      int         rrst_run;
      bit         vref_prev;
      bit         busy_chk;
      logic [7:0] exp;
      href_run  = 0;
      frame_pix = 0;
      rrst_run  = 0;
      vref_prev = 1'b0;
      busy_chk  = 1'b0;
      forever begin
         @(negedge clk);
         ncyc++;
         if (reset) begin
            href_run  = 0;
            frame_pix = 0;
            rrst_run  = 0;
            vref_prev = 1'b0;
            busy_chk  = 1'b0;
            continue;
         end
         if (fifo_rd && ptr == (SC - 1) * IW + IW - 1) rd_ncyc = ncyc;
         if (busy_chk) begin
            check("busy_after_last_pixel", busy, 0);
            busy_chk = 1'b0;
         end
         if (fifo_empty) check("rd_while_empty", fifo_rd, 0);
         if (fifo_rrst) begin
            rrst_run++;
         end else if (rrst_run != 0) begin
            check("rrst_length", rrst_run, 2);
            if (!fifo_empty) check("rd_after_rrst", fifo_rd, 1);
            rrst_run = 0;
         end
         if (buffer_vref && !vref_prev) begin
            check("vref_rise_with_ready", buffer_ready, 1);
            check("first_pixel_latency", ncyc - rd_ncyc, 2);
         end
         if (!buffer_vref && vref_prev) begin
            check("vref_span_pixels", frame_pix, NPIX);
            frame_pix = 0;
         end
         vref_prev = buffer_vref;
         if (buffer_href) begin
            href_run++;
         end else if (href_run != 0) begin
            check("href_burst_length", href_run, OW);
            href_run = 0;
         end
         if (buffer_ready) begin
            check("ready_framing", {buffer_href, buffer_vref}, 3);
            if (exp_q.size() == 0) begin
               check("unexpected_pixel_count", frame_pix + 1, 0);
            end else begin
               exp = exp_q.pop_front();
               $display("pixel %0d data=%02h expected=%02h", frame_pix, image_data, exp);
               check("pixel_data", image_data, exp);
            end
            frame_pix++;
            if (frame_pix == NPIX) busy_chk = 1'b1;
         end
      end
   end

   initial begin
      reset     = 1'b1;
      new_image = 1'b0;
      image_sel = 1'b0;
      repeat (3) tick();
      check("reset_outputs", {fifo_sel, fifo_rrst, fifo_rd, image_data,
                              buffer_ready, buffer_href, buffer_vref, busy}, 0);
      reset = 1'b0;
      tick();

      // Constant frame, left FIFO.
      start_frame(1'b0, 0);
      wait_idle();

      // Right FIFO, per-block values, with an ignored mid-frame request.
      start_frame(1'b1, 1);
      wait_ptr(600);
      image_sel = 1'b0;
      new_image = 1'b1;
      tick();
      new_image = 1'b0;
      check("fifo_sel_hold", fifo_sel, 1);
      wait_idle();
      check("queue_drained_sel1", exp_q.size(), 0);

      // Within-block ramp exercises truncation.
      start_frame(1'b0, 2);
      wait_idle();

      // Random empty gaps must not shift positions.
      stall_en = 1'b1;
      start_frame(1'b0, 1);
      wait_idle();
      stall_en = 1'b0;
      check("queue_drained_stall", exp_q.size(), 0);

      // Reset partway through the second block row of a saturated frame.
      start_frame(1'b1, 3);
      wait_ptr(12 * IW);
      reset = 1'b1;
      exp_q.delete();
      tick();
      check("mid_reset_outputs", {fifo_sel, fifo_rrst, fifo_rd, image_data,
                                  buffer_ready, buffer_href, buffer_vref, busy}, 0);
      reset = 1'b0;
      tick();
      start_frame(1'b0, 2);
      wait_idle();
      check("queue_drained_after_reset", exp_q.size(), 0);

      // Back-to-back: second request in the first cycle busy is low.
      start_frame(1'b1, 1);
      wait_idle();
      start_frame(1'b0, 2);
      wait_idle();
      repeat (4) tick();
      check("queue_drained_b2b", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_downsampler.md
Name: frame_downsampler

Overview:
- Upstream feeder of the disparity stage.
- On a new_image request, reads one full-resolution camera frame (left or right, chosen by image_sel) from the frame FIFO in raster order.
- Averages each SCALE×SCALE pixel block and delivers the reduced OUT_WIDTH×OUT_HEIGHT image as a pixel stream: image_data, qualified by buffer_ready, framed by buffer_href/buffer_vref.

Parameters:
- IN_WIDTH, 752, input pixels per line
- IN_HEIGHT, 480, input lines per frame
- SCALE_LOG2, 4, log2 of the block edge (block = 16×16)
- OUT_WIDTH, IN_WIDTH>>SCALE_LOG2 = 47, output pixels per row
- OUT_HEIGHT, IN_HEIGHT>>SCALE_LOG2 = 30, output rows
- RRST_CYCLES, 2, length of the FIFO read-pointer reset pulse
- ACC_W, 8+2*SCALE_LOG2 = 16, accumulator width

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- new_image  in  1  one-cycle frame request from disparity
- image_sel  in  1  0 = left FIFO, 1 = right FIFO; sampled with new_image
- fifo_empty  in  1  selected FIFO has no data
- fifo_data  in  8  FIFO read data, valid one cycle after fifo_rd
- fifo_sel  out  1  latched image_sel, drives the FIFO mux
- fifo_rrst  out  1  FIFO read-pointer reset
- fifo_rd  out  1  FIFO read enable
- image_data  out  8  averaged output pixel
- buffer_ready  out  1  image_data valid this cycle
- buffer_href  out  1  high across each output row burst
- buffer_vref  out  1  high from first to last output pixel of the frame
- busy  out  1  high whenever not in IDLE

Behaviour:
- Reset: all outputs 0, FSM to IDLE, accumulators and counters cleared. This applies mid-frame too; the partial frame is discarded.
- FSM states: IDLE, RRST, READ, DRAIN, EMIT.
- IDLE:
  - new_image=1 latches image_sel into fifo_sel, clears counters and goes to RRST.
  - new_image is ignored in every other state.
- RRST:
  - fifo_rrst=1 for exactly RRST_CYCLES cycles, then READ.
- READ:
  - fifo_rd = !fifo_empty; an empty FIFO stalls the read without losing position.
  - Each accepted read produces a sample one cycle later.
  - Column counter x runs 0..IN_WIDTH-1, line counter y runs 0..IN_HEIGHT-1.
  - Each sample adds into acc[x>>SCALE_LOG2] (ACC_W bits, no overflow possible).
  - When the read is issued for the last pixel of a line with (y & (SCALE-1)) == SCALE-1, go to DRAIN.
- DRAIN:
  - One cycle; the final sample is accumulated. Then EMIT.
- EMIT:
  - Emits OUT_WIDTH pixels on consecutive cycles, index 0 first.
  - For each pixel: image_data = acc[i][ACC_W-1:8] (truncating average), buffer_ready=1, buffer_href=1, and acc[i] cleared in the same cycle.
  - fifo_rd stays 0 throughout EMIT.
  - After index OUT_WIDTH-1: if this was the last output row, go to IDLE; otherwise return to READ.
- Framing:
  - buffer_href drops the cycle after the last pixel of the row.
  - buffer_vref rises with the first buffer_ready of the frame and falls the cycle after the last one.
- Latency:
  - First output pixel appears 2 cycles after the read of input pixel (IN_WIDTH-1, SCALE-1) is issued.
  - Each frame emits exactly OUT_WIDTH*OUT_HEIGHT = 1410 pixels.
- Discarded pixels: input pixels beyond OUT_WIDTH*SCALE columns or OUT_HEIGHT*SCALE lines are read and dropped (none at the defaults).
- fifo_data is ignored except in the cycle after fifo_rd.
- buffer_ready is never asserted outside EMIT.

Decomposition:
- Shared package:
  - FSM state encoding (3-bit, same style as the disparity FSM).
  - IN_/OUT_ dimensions, SCALE_LOG2, ACC_W and derived counter widths, so disparity and frame_downsampler agree on 47×30.
- One sub-module, block_accum:
  - OUT_WIDTH×ACC_W register bank with an add port (index, data, valid) and a read-and-clear port (index, strobe).
  - Add and read-and-clear never coincide, because the FSM serialises READ and EMIT.

Test Plan:
- Constant frame of 0x80, never empty → 1410 buffer_ready pulses, all image_data=0x80; 30 href bursts of 47 cycles each; vref spans exactly those; busy falls after the last pixel.
- Each 16×16 block filled with a constant value equal to its output index (row*47+col) mod 256 → output k equals k mod 256. Within-block ramp 0..255 → every output = 127 (truncation).
- Random fifo_empty gaps (~30%) on the constant-0x80 frame → output identical to the no-stall run; fifo_rd never high while fifo_empty=1.
- new_image with image_sel=1 → fifo_sel=1 and fifo_rrst high exactly 2 cycles before the first fifo_rd. A second new_image mid-frame is ignored and the pixel count stays 1410.
- Assert reset at input line 200 → all outputs 0 the next cycle. A fresh new_image then produces a clean 1410-pixel frame with no stale accumulator contribution (first output equals the new frame's block average).
- Back-to-back frames (new_image the cycle busy falls) → second frame correct; no buffer_ready from the first frame leaks into the second.
